// File: rtl/ac_scheduler.sv
// Heat/cool actuator sequencer with hysteresis deadband, minimum run time and
// post-run lockout so the actuators cannot short-cycle or change over directly.
module ac_scheduler #(
  parameter int unsigned HYST    = 2,
  parameter int unsigned MIN_RUN = 8,
  parameter int unsigned MIN_OFF = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [4:0] temperature,
  input  logic [4:0] setpoint,
  output logic       heating,
  output logic       cooling,
  output logic       lockout,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAT = 2'd1,
    S_COOL = 2'd2,
    S_LOCK = 2'd3
  } state_e;

  localparam logic [5:0]       HYST_W   = 6'(HYST);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MIN_RUN - 1);
  localparam logic [CNT_W-1:0] OFF_INIT = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] off_cnt_q, off_cnt_d;
  logic             heating_q, cooling_q, lockout_q;

  logic [5:0] temp_ext_s;
  logic [5:0] sp_ext_s;
  logic       heat_req_s;
  logic       cool_req_s;
  logic       heat_stop_s;
  logic       cool_stop_s;
  logic       run_done_s;
  logic [CNT_W-1:0] run_inc_s;

  // Six-bit arithmetic keeps temperature+HYST and setpoint+HYST from wrapping.
  assign temp_ext_s  = {1'b0, temperature};
  assign sp_ext_s    = {1'b0, setpoint};
  assign heat_req_s  = (temp_ext_s + HYST_W) <= sp_ext_s;
  assign cool_req_s  = temp_ext_s >= (sp_ext_s + HYST_W);
  assign heat_stop_s = (temp_ext_s >= sp_ext_s) || !enable;
  assign cool_stop_s = (temp_ext_s <= sp_ext_s) || !enable;
  // Counter holds (cycles already on - 1) at the evaluating edge.
  assign run_done_s  = run_cnt_q >= RUN_LAST;
  assign run_inc_s   = (run_cnt_q == CNT_MAX) ? run_cnt_q : (run_cnt_q + CNT_ONE);

  // Next-state and counter update logic.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_inc_s;
    off_cnt_d = CNT_ZERO;
    case (state_q)
      S_IDLE: begin
        run_cnt_d = CNT_ZERO;
        if (enable && heat_req_s) begin
          state_d = S_HEAT;
        end else if (enable && cool_req_s) begin
          state_d = S_COOL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HEAT: begin
        if (heat_stop_s && run_done_s) begin
          state_d   = S_LOCK;
          run_cnt_d = CNT_ZERO;
          off_cnt_d = OFF_INIT;
        end else begin
          state_d = S_HEAT;
        end
      end
      S_COOL: begin
        if (cool_stop_s && run_done_s) begin
          state_d   = S_LOCK;
          run_cnt_d = CNT_ZERO;
          off_cnt_d = OFF_INIT;
        end else begin
          state_d = S_COOL;
        end
      end
      S_LOCK: begin
        run_cnt_d = CNT_ZERO;
        // Leave on the edge the counter would hit zero: MIN_OFF lockout cycles.
        if (off_cnt_q <= CNT_ONE) begin
          state_d   = S_IDLE;
          off_cnt_d = CNT_ZERO;
        end else begin
          state_d   = S_LOCK;
          off_cnt_d = off_cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        run_cnt_d = CNT_ZERO;
        off_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // State, counters and output drive registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      run_cnt_q <= CNT_ZERO;
      off_cnt_q <= CNT_ZERO;
      heating_q <= 1'b0;
      cooling_q <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      off_cnt_q <= off_cnt_d;
      heating_q <= (state_d == S_HEAT);
      cooling_q <= (state_d == S_COOL);
      lockout_q <= (state_d == S_LOCK);
    end
  end

  assign heating = heating_q;
  assign cooling = cooling_q;
  assign lockout = lockout_q;
  assign state   = state_q;

endmodule

// File: tb/tb_ac_scheduler.sv
// Directed bench for ac_scheduler: per-cycle vector table plus a long-run
// sequence measuring run and lockout durations.
module tb_ac_scheduler;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [4:0] temperature;
  logic [4:0] setpoint;
  logic       heating;
  logic       cooling;
  logic       lockout;
  logic [1:0] state;

  int n_checks;
  int n_fail;

  typedef struct {
    int         reps;
    logic       rst;
    logic       en;
    logic [4:0] temp;
    logic [4:0] sp;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  ac_scheduler #(.HYST(2), .MIN_RUN(8), .MIN_OFF(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .temperature(temperature), .setpoint(setpoint),
    .heating(heating), .cooling(cooling), .lockout(lockout), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic v(input int reps, input logic r, input logic en,
                   input logic [4:0] t, input logic [4:0] sp, input logic [1:0] st);
    vec_t x;
    x.reps = reps; x.rst = r; x.en = en; x.temp = t; x.sp = sp; x.st = st;
    vecs.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    int hc;
    int lc;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1; enable = 1'b1; temperature = 5'd10; setpoint = 5'd20;

    // 1. reset, then heat on first edge after release; min run then lockout
    v(2, 1'b1, 1'b1, 5'd10, 5'd20, 2'd0);
    v(1, 1'b0, 1'b1, 5'd10, 5'd20, 2'd1);
    v(7, 1'b0, 1'b1, 5'd20, 5'd20, 2'd1);
    v(4, 1'b0, 1'b1, 5'd20, 5'd20, 2'd3);
    v(1, 1'b0, 1'b1, 5'd20, 5'd20, 2'd0);
    // 2. deadband
    v(10, 1'b0, 1'b1, 5'd19, 5'd20, 2'd0);
    v(10, 1'b0, 1'b1, 5'd21, 5'd20, 2'd0);
    // 3. minimum run: stop seen after 3 cycles, heating still 8
    v(3, 1'b0, 1'b1, 5'd18, 5'd20, 2'd1);
    v(5, 1'b0, 1'b1, 5'd20, 5'd20, 2'd1);
    v(4, 1'b0, 1'b1, 5'd20, 5'd20, 2'd3);
    v(1, 1'b0, 1'b1, 5'd20, 5'd20, 2'd0);
    // 4. long cool run of 12, lockout ignores temperature=5, heat on first IDLE edge
    v(12, 1'b0, 1'b1, 5'd22, 5'd20, 2'd2);
    v(1, 1'b0, 1'b1, 5'd20, 5'd20, 2'd3);
    v(3, 1'b0, 1'b1, 5'd5, 5'd20, 2'd3);
    v(1, 1'b0, 1'b1, 5'd5, 5'd20, 2'd0);
    v(1, 1'b0, 1'b1, 5'd5, 5'd20, 2'd1);
    // 5a. enable dropped at cycle 2 of that heat run: still 8 cycles, no restart
    v(1, 1'b0, 1'b1, 5'd5, 5'd20, 2'd1);
    v(6, 1'b0, 1'b0, 5'd5, 5'd20, 2'd1);
    v(4, 1'b0, 1'b0, 5'd5, 5'd20, 2'd3);
    v(6, 1'b0, 1'b0, 5'd5, 5'd20, 2'd0);
    // 5b. reset mid-heat, release straight into heat with no lockout
    v(3, 1'b0, 1'b1, 5'd18, 5'd20, 2'd1);
    v(1, 1'b1, 1'b1, 5'd18, 5'd20, 2'd0);
    v(1, 1'b0, 1'b1, 5'd18, 5'd20, 2'd1);
    v(7, 1'b0, 1'b1, 5'd20, 5'd20, 2'd1);
    v(4, 1'b0, 1'b1, 5'd20, 5'd20, 2'd3);
    v(1, 1'b0, 1'b1, 5'd20, 5'd20, 2'd0);
    // 6. arithmetic boundaries
    v(3, 1'b0, 1'b1, 5'd0, 5'd1, 2'd0);
    v(3, 1'b0, 1'b1, 5'd31, 5'd31, 2'd0);
    v(1, 1'b0, 1'b1, 5'd0, 5'd2, 2'd1);
    v(1, 1'b1, 1'b1, 5'd0, 5'd2, 2'd0);
    v(1, 1'b0, 1'b1, 5'd31, 5'd1, 2'd2);
    v(1, 1'b1, 1'b1, 5'd31, 5'd1, 2'd0);
    v(1, 1'b0, 1'b1, 5'd1, 5'd31, 2'd1);
    v(1, 1'b1, 1'b1, 5'd1, 5'd31, 2'd0);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        rst = vecs[i].rst; enable = vecs[i].en;
        temperature = vecs[i].temp; setpoint = vecs[i].sp;
        tick();
        chk("state", i, int'(state), int'(vecs[i].st));
        chk("heating", i, int'(heating), int'(vecs[i].st == 2'd1));
        chk("cooling", i, int'(cooling), int'(vecs[i].st == 2'd2));
        chk("lockout", i, int'(lockout), int'(vecs[i].st == 2'd3));
      end
    end

    // Long heat run past counter saturation: 25 heating cycles, then 4 lockout.
    rst = 1'b1; enable = 1'b1; temperature = 5'd10; setpoint = 5'd20;
    tick();
    rst = 1'b0;
    hc = 0;
    for (int i = 0; i < 100; i++) begin
      if (hc == 25) temperature = 5'd20;
      tick();
      chk("no_overlap", 1000 + i, int'(heating && cooling), 0);
      if (heating) hc++;
      else if (hc > 0) break;
    end
    chk("long_run_len", 1000, hc, 25);
    chk("lock_after_run", 1001, int'(lockout), 1);
    lc = 0;
    if (lockout) lc = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (lockout) lc++;
      else break;
    end
    chk("lock_len", 1002, lc, 4);
    chk("idle_after_lock", 1003, int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
